hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage pipeline.
- Consumes hazard indications from ID, EX and MEM, plus instruction/data cache and store-buffer status.
- Drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable.
- Owns the only sequential hazard state in the core:
  - multi-cycle multiply wait;
  - data-cache miss wait;
  - a stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/stall_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// control bundle layout, architectural constants and the source-match helper.
package hazard_ctrl_pkg;

  // Register index width of the integer register file.
  localparam int REG_W = 5;

  // Canonical NOP (addi x0, x0, 0) loaded into a flushed pipeline register.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Hazard FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_MUL_WAIT  = 2'd1,
    HZ_DMISS     = 2'd2,
    HZ_DMISS_MUL = 2'd3
  } hz_state_e;

  // Plain constants for the state register.
  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT  = 2'd1;
  localparam logic [1:0] ST_DMISS     = 2'd2;
  localparam logic [1:0] ST_DMISS_MUL = 2'd3;

  // Every pipeline control output, decoded together so that each priority
  // row defines the full bundle and nothing leaks between rows.
  typedef struct packed {
    logic pc_we;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic flush_if;
    logic flush_id;
    logic flush_ex;
    logic mul_busy;
  } hz_ctrl_t;

  // A source operand depends on the EX destination only when it is really
  // read and the destination is not x0 (writes to x0 are discarded).
  function automatic logic src_hazard(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] rd
  );
    return use_src && (src == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Saturating event counter with enable and synchronous active-low clear.
module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count enabled cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Holds the
// multiply-wait and data-miss-wait FSM and a stall-cycle counter; every
// pipeline control output is combinational from state and current inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mul,
  input  logic             ex_redirect,
  input  logic             imiss,
  input  logic             dmiss,
  input  logic             dfill_done,
  input  logic             mem_is_store,
  input  logic             sb_full,
  output logic             pc_we,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The entry cycle (RUN with ex_is_mul) counts as the first multiply cycle,
  // and MUL_WAIT exits after the cycle that sees a zero count, so loading
  // MUL_LAT-2 gives exactly MUL_LAT held cycles in total.
  localparam int                  MC_W     = $clog2(MUL_LAT);
  localparam logic [MC_W-1:0]     MUL_LOAD = MC_W'(MUL_LAT - 2);

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [MC_W-1:0] mul_cnt_reg;
  logic [MC_W-1:0] mul_cnt_next;

  logic            freeze;
  logic            mul_hold;
  logic            load_use;
  hz_ctrl_t        ctrl;

  // ---------------------------------------------------------------------
  // Load-use compare, one comparator per ID source operand.
  // ---------------------------------------------------------------------
  logic [REG_W-1:0] src_idx [2];
  logic [1:0]       src_use;
  logic [1:0]       src_hit;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;
  assign src_use    = {id_use_rs2, id_use_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_hazard(src_use[gi], src_idx[gi], ex_rd);
  end

  assign load_use = ex_is_load && (|src_hit);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // Next-state and multiply countdown. A miss from RUN wins over a multiply
  // (the multiply is still in EX afterwards and starts once the fill is in).
  // The MUL_WAIT cycle that sees a miss still counts as multiply progress,
  // and the count is then frozen until the fill completes.
  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (dmiss) begin
          state_next = ST_DMISS;
        end else if (ex_is_mul) begin
          state_next   = ST_MUL_WAIT;
          mul_cnt_next = MUL_LOAD;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_cnt_reg != '0) begin
          mul_cnt_next = mul_cnt_reg - MC_W'(1);
        end
        if (dmiss) begin
          state_next = ST_DMISS_MUL;
        end else if (mul_cnt_reg == '0) begin
          state_next = ST_RUN;
        end
      end
      ST_DMISS: begin
        if (dfill_done) begin
          state_next = ST_RUN;
        end
      end
      ST_DMISS_MUL: begin
        if (dfill_done) begin
          state_next = ST_MUL_WAIT;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State and countdown registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      mul_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------

  assign freeze   = (state_reg == ST_DMISS) || (state_reg == ST_DMISS_MUL) ||
                    dmiss || (mem_is_store && sb_full);
  assign mul_hold = (state_reg == ST_MUL_WAIT) ||
                    ((state_reg == ST_RUN) && ex_is_mul);

  // Priority decode; the first matching row sets the whole bundle. A held
  // redirect is simply re-seen once freeze/multiply release, so it is never
  // lost. No row asserts a stall and a flush for the same register.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      ctrl = '0;
    end else if (freeze) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.stall_ex = 1'b1;
    end else if (mul_hold) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.flush_ex = 1'b1;
      ctrl.mul_busy = 1'b1;
    end else if (ex_redirect) begin
      ctrl.flush_if = 1'b1;
      ctrl.flush_id = 1'b1;
      ctrl.pc_we    = 1'b1;
    end else if (load_use) begin
      ctrl.stall_if = 1'b1;
      ctrl.flush_id = 1'b1;
    end else if (imiss) begin
      ctrl.flush_if = 1'b1;
    end else begin
      ctrl.pc_we = 1'b1;
    end
  end

  assign pc_we    = ctrl.pc_we;
  assign stall_if = ctrl.stall_if;
  assign stall_id = ctrl.stall_id;
  assign stall_ex = ctrl.stall_ex;
  assign flush_if = ctrl.flush_if;
  assign flush_id = ctrl.flush_id;
  assign flush_ex = ctrl.flush_ex;
  assign mul_busy = ctrl.mul_busy;

  // Every cycle without a PC update is a stall cycle; reset clears it.
  stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk    (clk),
    .clear_n(reset),
    .en     (!ctrl.pc_we),
    .count  (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives inputs, pushes the expected
// control bundle and stall count to a scoreboard queue, and pops/compares it
// at the falling edge of the same cycle.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  // Expected control bundles: {pc_we, stall_if, stall_id, stall_ex,
  //                            flush_if, flush_id, flush_ex, mul_busy}
  localparam logic [7:0] V_ZERO   = 8'b0000_0000;
  localparam logic [7:0] V_RUN    = 8'b1000_0000;
  localparam logic [7:0] V_FREEZE = 8'b0111_0000;
  localparam logic [7:0] V_MUL    = 8'b0110_0011;
  localparam logic [7:0] V_REDIR  = 8'b1000_1100;
  localparam logic [7:0] V_LU     = 8'b0100_0100;
  localparam logic [7:0] V_IMISS  = 8'b0000_1000;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_is_mul;
  logic             ex_redirect;
  logic             imiss;
  logic             dmiss;
  logic             dfill_done;
  logic             mem_is_store;
  logic             sb_full;
  logic             pc_we;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  logic [7:0]       obs_vec;

  typedef struct {
    string            tag;
    logic [7:0]       vec;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               checks;
  int               errors;

  hazard_ctrl #(
    .MUL_LAT(4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_is_mul   (ex_is_mul),
    .ex_redirect (ex_redirect),
    .imiss       (imiss),
    .dmiss       (dmiss),
    .dfill_done  (dfill_done),
    .mem_is_store(mem_is_store),
    .sb_full     (sb_full),
    .pc_we       (pc_we),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .mul_busy    (mul_busy),
    .stall_cycles(stall_cycles)
  );

  assign obs_vec = {pc_we, stall_if, stall_id, stall_ex,
                    flush_if, flush_id, flush_ex, mul_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: record expectations, sample at the falling edge, advance to
  // just after the next rising edge. The counter model adds one for every
  // expected pc_we=0 cycle and is cleared by a reset cycle.
  task automatic step(input string tag, input logic [7:0] exp, input bit in_rst);
    exp_t e;
    e.tag = tag;
    e.vec = exp;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (in_rst) exp_cnt = '0;
    else if (!exp[7] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1;
    #4;
    e = sb_q.pop_front();
    checks++;
    assert (obs_vec === e.vec) else begin
      errors++;
      $error("FAIL %s ctrl got %b expected %b", e.tag, obs_vec, e.vec);
    end
    checks++;
    assert (stall_cycles === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cycles got %0d expected %0d", e.tag, stall_cycles, e.cnt);
    end
    $display("step %-12s ctrl=%b stall_cycles=%0d", e.tag, obs_vec, stall_cycles);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_cnt      = '0;
    reset        = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_use_rs1   = 1'b0;
    id_use_rs2   = 1'b0;
    ex_rd        = '0;
    ex_is_load   = 1'b0;
    ex_is_mul    = 1'b0;
    ex_redirect  = 1'b0;
    imiss        = 1'b0;
    dmiss        = 1'b0;
    dfill_done   = 1'b0;
    mem_is_store = 1'b0;
    sb_full      = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: outputs forced low, counter cleared.
    ex_redirect = 1'b1;
    step("rst0", V_ZERO, 1'b1);
    ex_redirect = 1'b0;
    step("rst1", V_ZERO, 1'b1);
    reset = 1'b1;
    step("idle", V_RUN, 1'b0);

    // Load-use on rs2, then same with ex_rd=0, then unused rs1 match.
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    step("lu_rs2", V_LU, 1'b0);
    ex_rd = 5'd0; id_rs2 = 5'd0;
    step("lu_x0", V_RUN, 1'b0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd5;
    step("lu_unused", V_RUN, 1'b0);
    id_use_rs1 = 1'b1;
    step("lu_rs1", V_LU, 1'b0);
    ex_is_load = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    step("lu_clear", V_RUN, 1'b0);

    // Multiply pulse: exactly 4 held cycles, then RUN.
    ex_is_mul = 1'b1;
    step("mul_c1", V_MUL, 1'b0);
    ex_is_mul = 1'b0;
    for (int i = 0; i < 3; i++) step("mul_wait", V_MUL, 1'b0);
    step("mul_done", V_RUN, 1'b0);

    // Miss at the 2nd MUL_WAIT cycle, fill 10 cycles later: 4+10 held.
    ex_is_mul = 1'b1;
    step("mm_c1", V_MUL, 1'b0);
    ex_is_mul = 1'b0;
    step("mm_c2", V_MUL, 1'b0);
    dmiss = 1'b1;
    step("mm_miss", V_FREEZE, 1'b0);
    for (int i = 0; i < 9; i++) step("mm_frz", V_FREEZE, 1'b0);
    dmiss = 1'b0; dfill_done = 1'b1;
    step("mm_fill", V_FREEZE, 1'b0);
    dfill_done = 1'b0;
    step("mm_resume", V_MUL, 1'b0);
    step("mm_done", V_RUN, 1'b0);

    // Redirect held through a freeze is acted on right after the fill.
    dmiss = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) step("rd_frz", V_FREEZE, 1'b0);
    dmiss = 1'b0; dfill_done = 1'b1;
    step("rd_fill", V_FREEZE, 1'b0);
    dfill_done = 1'b0;
    step("rd_act", V_REDIR, 1'b0);
    // Redirect outranks load-use and imiss.
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; imiss = 1'b1;
    step("rd_prio", V_REDIR, 1'b0);
    ex_redirect = 1'b0;
    step("lu_prio", V_LU, 1'b0);
    ex_is_load = 1'b0; id_use_rs1 = 1'b0;
    step("imiss", V_IMISS, 1'b0);
    imiss = 1'b0;
    step("rd_clear", V_RUN, 1'b0);

    // Store-buffer freeze outranks imiss.
    mem_is_store = 1'b1; sb_full = 1'b1; imiss = 1'b1;
    for (int i = 0; i < 3; i++) step("sb_frz", V_FREEZE, 1'b0);
    sb_full = 1'b0;
    step("sb_imiss", V_IMISS, 1'b0);
    mem_is_store = 1'b0; imiss = 1'b0;
    step("sb_clear", V_RUN, 1'b0);

    // dmiss and dfill_done together from RUN: the fill is for an older miss.
    dmiss = 1'b1; dfill_done = 1'b1;
    step("dd_both", V_FREEZE, 1'b0);
    dmiss = 1'b0; dfill_done = 1'b0;
    step("dd_wait", V_FREEZE, 1'b0);
    dfill_done = 1'b1;
    step("dd_fill", V_FREEZE, 1'b0);
    dfill_done = 1'b0;
    step("dd_run", V_RUN, 1'b0);

    // Stale fill in RUN is ignored; multiply and miss together prefer miss.
    dfill_done = 1'b1;
    step("stale_run", V_RUN, 1'b0);
    dfill_done = 1'b0; ex_is_mul = 1'b1; dmiss = 1'b1;
    step("mul_miss", V_FREEZE, 1'b0);
    dmiss = 1'b0; dfill_done = 1'b1;
    step("mul_fill", V_FREEZE, 1'b0);
    dfill_done = 1'b0;
    step("mul_after", V_MUL, 1'b0);
    ex_is_mul = 1'b0;
    for (int i = 0; i < 3; i++) step("mul_after_w", V_MUL, 1'b0);
    step("mul_after_d", V_RUN, 1'b0);

    // Reset mid-DMISS, then a stale fill after release.
    dmiss = 1'b1;
    step("rm_miss", V_FREEZE, 1'b0);
    dmiss = 1'b0;
    step("rm_wait", V_FREEZE, 1'b0);
    reset = 1'b0;
    step("rm_reset", V_ZERO, 1'b1);
    reset = 1'b1;
    step("rm_run", V_RUN, 1'b0);
    dfill_done = 1'b1;
    step("rm_stale", V_RUN, 1'b0);
    dfill_done = 1'b0;
    step("rm_after", V_RUN, 1'b0);

    // Reset mid-multiply returns to RUN with no leftover count.
    ex_is_mul = 1'b1;
    step("rmm_c1", V_MUL, 1'b0);
    ex_is_mul = 1'b0;
    reset = 1'b0;
    step("rmm_reset", V_ZERO, 1'b1);
    reset = 1'b1;
    step("rmm_run", V_RUN, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
